// File: rtl/mips_fetch_ctrl.sv
// MIPS fetch sequencer: owns the PC, issues one instruction-memory read at a time
// and presents each fetched word to decode over a valid/ready handshake.
module mips_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [1:0]  state_o
);

   localparam int            CW       = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [31:0]   PC_INIT  = {RESET_PC[31:2], 2'b00};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   opc_q, opc_d;
   logic          valid_q, valid_d;

   // Low address bits of a redirect target are discarded by design.
   logic unused_rpc_lsb;
   assign unused_rpc_lsb = ^redirect_pc[1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      valid_d = valid_q;

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_d   = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_ONE) begin
               instr_d = mem_rdata;
               opc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               cnt_d   = '0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_HOLD: begin
            // Handshake: the pair is transferred on any edge where o_valid and
            // i_ready are both high; the pair is frozen until then.
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = enable ? S_ISSUE : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything; any in-flight read is simply forgotten.
      if (redirect_valid) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         cnt_d   = '0;
         valid_d = 1'b0;
         state_d = enable ? S_ISSUE : S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= PC_INIT;
         cnt_q   <= '0;
         instr_q <= '0;
         opc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         valid_q <= valid_d;
      end
   end

   assign mem_addr      = pc_q;
   assign mem_rd_en     = (state_q == S_ISSUE);
   assign o_instruction = instr_q;
   assign o_pc          = opc_q;
   assign o_valid       = valid_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Directed bench for mips_fetch_ctrl: three instances cover latency 1, latency 3
// and a PC that wraps past 32'hFFFF_FFFC.
module tb_mips_fetch_ctrl;

   localparam logic [1:0] ST_IDLE = 2'd0;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: latency 1, RESET_PC 0
   logic        a_enable, a_redirect, a_ready, a_rd_en, a_valid;
   logic [31:0] a_rpc, a_addr, a_rdata, a_instr, a_pc;
   logic [1:0]  a_state;
   // Instance B: latency 3, RESET_PC 0
   logic        b_enable, b_redirect, b_ready, b_rd_en, b_valid;
   logic [31:0] b_rpc, b_addr, b_rdata, b_instr, b_pc;
   logic [1:0]  b_state;
   // Instance C: latency 1, RESET_PC FFFF_FFF8
   logic        c_enable, c_redirect, c_ready, c_rd_en, c_valid;
   logic [31:0] c_rpc, c_addr, c_rdata, c_instr, c_pc;
   logic [1:0]  c_state;

   int acc10;

   mips_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) u_dut_a (
      .clk(clk), .reset(reset), .enable(a_enable), .redirect_valid(a_redirect),
      .redirect_pc(a_rpc), .mem_addr(a_addr), .mem_rd_en(a_rd_en), .mem_rdata(a_rdata),
      .o_instruction(a_instr), .o_pc(a_pc), .o_valid(a_valid), .i_ready(a_ready),
      .state_o(a_state)
   );

   mips_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(3)) u_dut_b (
      .clk(clk), .reset(reset), .enable(b_enable), .redirect_valid(b_redirect),
      .redirect_pc(b_rpc), .mem_addr(b_addr), .mem_rd_en(b_rd_en), .mem_rdata(b_rdata),
      .o_instruction(b_instr), .o_pc(b_pc), .o_valid(b_valid), .i_ready(b_ready),
      .state_o(b_state)
   );

   mips_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(1)) u_dut_c (
      .clk(clk), .reset(reset), .enable(c_enable), .redirect_valid(c_redirect),
      .redirect_pc(c_rpc), .mem_addr(c_addr), .mem_rd_en(c_rd_en), .mem_rdata(c_rdata),
      .o_instruction(c_instr), .o_pc(c_pc), .o_valid(c_valid), .i_ready(c_ready),
      .state_o(c_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: word[i] = 32'h1000_0000 + i, driven only in the exact data cycle.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   logic [32:0] a_pipe = '0;
   logic [32:0] c_pipe = '0;
   logic [32:0] b_pipe0 = '0, b_pipe1 = '0, b_pipe2 = '0;

   always @(posedge clk) begin
      a_pipe  <= {a_rd_en, a_addr};
      c_pipe  <= {c_rd_en, c_addr};
      b_pipe0 <= {b_rd_en, b_addr};
      b_pipe1 <= b_pipe0;
      b_pipe2 <= b_pipe1;
   end

   assign a_rdata = a_pipe[32]  ? mem_word(a_pipe[31:0])  : 32'hDEAD_BEEF;
   assign c_rdata = c_pipe[32]  ? mem_word(c_pipe[31:0])  : 32'hDEAD_BEEF;
   assign b_rdata = b_pipe2[32] ? mem_word(b_pipe2[31:0]) : 32'hDEAD_BEEF;

   // Driver helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard check
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      a_enable = 0; a_redirect = 0; a_ready = 0; a_rpc = '0;
      b_enable = 0; b_redirect = 0; b_ready = 0; b_rpc = '0;
      c_enable = 0; c_redirect = 0; c_ready = 0; c_rpc = '0;
      acc10 = 0;

      step();
      step();
      check("rst_a_valid", 32'(a_valid), 32'd0);
      check("rst_a_rd_en", 32'(a_rd_en), 32'd0);
      check("rst_a_addr",  a_addr,  32'h0000_0000);
      check("rst_a_instr", a_instr, 32'h0000_0000);
      check("rst_a_pc",    a_pc,    32'h0000_0000);
      check("rst_a_state", 32'(a_state), 32'(ST_IDLE));
      check("rst_c_addr",  c_addr,  32'hFFFF_FFF8);
      check("rst_c_state", 32'(c_state), 32'(ST_IDLE));

      // Sequential fetch, latency 1: issue every 3 cycles
      reset    = 1'b1;
      a_enable = 1'b1;
      a_ready  = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         check("seq_rd_en", 32'(a_rd_en), 32'((c % 3) == 1));
         check("seq_valid", 32'(a_valid), 32'((c % 3) == 0));
         if ((c % 3) == 1) check("seq_addr", a_addr, 32'((c / 3) * 4));
         if ((c % 3) == 0) begin
            check("seq_pc",    a_pc,    32'((c / 3 - 1) * 4));
            check("seq_instr", a_instr, 32'h1000_0000 + 32'(c / 3 - 1));
         end
      end
      step();  // c9
      check("seq_pc8",    a_pc,    32'h0000_0008);
      check("seq_instr8", a_instr, 32'h1000_0002);
      check("seq_valid8", 32'(a_valid), 32'd1);

      // Back-pressure for 5 cycles at o_pc = 8
      a_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_valid", 32'(a_valid), 32'd1);
         check("bp_pc",    a_pc,    32'h0000_0008);
         check("bp_instr", a_instr, 32'h1000_0002);
         check("bp_rd_en", 32'(a_rd_en), 32'd0);
      end
      a_ready = 1'b1;
      step();  // c15
      check("bp_rel_rd_en", 32'(a_rd_en), 32'd1);
      check("bp_rel_addr",  a_addr, 32'h0000_000C);
      step();
      step();  // c17
      check("seq_pcC",    a_pc,    32'h0000_000C);
      check("seq_instrC", a_instr, 32'h1000_0003);
      step();  // c18
      check("seq_addr10", a_addr, 32'h0000_0010);
      step();
      step();  // c20
      check("hold_valid10", 32'(a_valid), 32'd1);
      check("hold_pc10",    a_pc,    32'h0000_0010);
      check("hold_instr10", a_instr, 32'h1000_0004);

      // Redirect and accept in the same HOLD cycle
      if (a_valid && a_ready && a_pc == 32'h10) acc10++;
      a_redirect = 1'b1;
      a_rpc      = 32'h0000_0080;
      step();  // c21
      a_redirect = 1'b0;
      if (a_valid && a_ready && a_pc == 32'h10) acc10++;
      check("rdh_valid0", 32'(a_valid), 32'd0);
      check("rdh_rd_en",  32'(a_rd_en), 32'd1);
      check("rdh_addr",   a_addr, 32'h0000_0080);
      step();  // c22
      if (a_valid && a_ready && a_pc == 32'h10) acc10++;
      check("rdh_valid1", 32'(a_valid), 32'd0);
      step();  // c23
      if (a_valid && a_ready && a_pc == 32'h10) acc10++;
      check("rdh_accepts10", 32'(acc10), 32'd1);
      check("rdh_pc80",      a_pc,    32'h0000_0080);
      check("rdh_instr80",   a_instr, 32'h1000_0020);
      check("rdh_valid80",   32'(a_valid), 32'd1);
      a_enable = 1'b0;

      // Redirect in WAIT, latency 3
      b_enable = 1'b1;
      b_ready  = 1'b1;
      step();  // b c1
      check("rdw_rd_en0", 32'(b_rd_en), 32'd1);
      check("rdw_addr0",  b_addr, 32'h0000_0000);
      step();
      step();
      step();  // c4
      check("rdw_lat_valid", 32'(b_valid), 32'd0);
      step();  // c5
      check("rdw_valid0", 32'(b_valid), 32'd1);
      check("rdw_pc0",    b_pc,    32'h0000_0000);
      check("rdw_instr0", b_instr, 32'h1000_0000);
      step();  // c6
      check("rdw_rd_en4", 32'(b_rd_en), 32'd1);
      check("rdw_addr4",  b_addr, 32'h0000_0004);
      step();  // c7, fetch of 4 in flight
      b_redirect = 1'b1;
      b_rpc      = 32'h0000_0043;
      step();  // c8
      b_redirect = 1'b0;
      check("rdw_rd_en40", 32'(b_rd_en), 32'd1);
      check("rdw_addr40",  b_addr, 32'h0000_0040);
      check("rdw_valid_c8", 32'(b_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("rdw_no_word4", 32'(b_valid), 32'd0);
      end
      step();  // c12
      check("rdw_valid40", 32'(b_valid), 32'd1);
      check("rdw_pc40",    b_pc,    32'h0000_0040);
      check("rdw_instr40", b_instr, 32'h1000_0010);
      b_enable = 1'b0;

      // Enable drop during WAIT and PC wrap
      c_enable = 1'b1;
      c_ready  = 1'b1;
      step();  // c1
      check("wrap_rd_en0", 32'(c_rd_en), 32'd1);
      check("wrap_addr0",  c_addr, 32'hFFFF_FFF8);
      step();  // c2, WAIT
      c_enable = 1'b0;
      step();  // c3
      check("wrap_valid0", 32'(c_valid), 32'd1);
      check("wrap_pc0",    c_pc,    32'hFFFF_FFF8);
      check("wrap_instr0", c_instr, 32'h4FFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         step();
         check("wrap_idle_rd_en", 32'(c_rd_en), 32'd0);
         check("wrap_idle_valid", 32'(c_valid), 32'd0);
         check("wrap_idle_addr",  c_addr, 32'hFFFF_FFFC);
      end
      c_enable = 1'b1;
      step();  // c7
      check("wrap_rd_en1", 32'(c_rd_en), 32'd1);
      check("wrap_addr1",  c_addr, 32'hFFFF_FFFC);
      step();
      step();  // c9
      check("wrap_pc1",    c_pc,    32'hFFFF_FFFC);
      check("wrap_instr1", c_instr, 32'h4FFF_FFFF);
      step();  // c10
      check("wrap_rd_en2", 32'(c_rd_en), 32'd1);
      check("wrap_addr2",  c_addr, 32'h0000_0000);
      step();
      step();  // c12
      check("wrap_pc2",    c_pc,    32'h0000_0000);
      check("wrap_instr2", c_instr, 32'h1000_0000);
      c_enable = 1'b0;

      // Asynchronous reset in the middle of a WAIT
      b_enable = 1'b1;
      step();  // d1
      check("ar_rd_en44", 32'(b_rd_en), 32'd1);
      check("ar_addr44",  b_addr, 32'h0000_0044);
      step();  // d2, WAIT
      #3;
      reset = 1'b0;
      #1;
      check("ar_valid",  32'(b_valid), 32'd0);
      check("ar_addr",   b_addr,  32'h0000_0000);
      check("ar_rd_en",  32'(b_rd_en), 32'd0);
      check("ar_pc",     b_pc,    32'h0000_0000);
      check("ar_instr",  b_instr, 32'h0000_0000);
      check("ar_c_addr", c_addr,  32'hFFFF_FFF8);
      step();  // d3
      reset = 1'b1;
      step();  // d4, late data for 44 arrives now
      check("ar_rel_rd_en", 32'(b_rd_en), 32'd1);
      check("ar_rel_addr",  b_addr, 32'h0000_0000);
      for (int k = 0; k < 3; k++) begin
         step();
         check("ar_late_ignored", 32'(b_valid), 32'd0);
      end
      step();  // d8
      check("ar_valid0", 32'(b_valid), 32'd1);
      check("ar_pc0",    b_pc,    32'h0000_0000);
      check("ar_instr0", b_instr, 32'h1000_0000);
      b_enable = 1'b0;

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
